// File: rtl/arch_restore_sequencer_if.sv
// Handshake bundle between the restore sequencer, the architectural-state
// source (request/response) and the core register-write port.
interface arch_restore_sequencer_if #(
  parameter int XLEN = 64
);
  logic            src_req_valid;
  logic            src_req_ready;
  logic [7:0]      src_req_addr;
  logic            src_resp_valid;
  logic [XLEN-1:0] src_resp_data;

  logic            wr_valid;
  logic            wr_ready;
  logic [1:0]      wr_sel;
  logic [4:0]      wr_idx;
  logic [XLEN-1:0] wr_data;

  modport master (
    output src_req_valid, src_req_addr, wr_valid, wr_sel, wr_idx, wr_data,
    input  src_req_ready, src_resp_valid, src_resp_data, wr_ready
  );

  modport slave (
    input  src_req_valid, src_req_addr, wr_valid, wr_sel, wr_idx, wr_data,
    output src_req_ready, src_resp_valid, src_resp_data, wr_ready
  );
endinterface

// File: rtl/arch_restore_sequencer.sv
// Architectural state restore sequencer: walks XPR1..31, optional FPR0..31,
// CSR slots and finally PC, fetching each record from the source and writing
// it into the core while the core is held in reset.
module arch_restore_sequencer #(
  parameter int XLEN    = 64,
  parameter int NUM_CSR = 24,
  parameter int TIMEOUT = 1023
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             fpr_en_i,
  arch_restore_sequencer_if.master         bus,
  output logic                             core_hold_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             error_o
);
  // One extra bit so the counter can always hold TIMEOUT itself.
  localparam int          CW       = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);
  localparam logic [4:0]  CSR_LAST = 5'(NUM_CSR - 1);
  localparam logic [7:0]  PC_ADDR  = 8'(63 + NUM_CSR);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE, S_ERROR} state_e;
  typedef enum logic [1:0] {G_XPR, G_FPR, G_CSR, G_PC} grp_e;

  state_e          state_q, state_d;
  grp_e            grp_q, grp_d;
  logic [4:0]      idx_q, idx_d;
  logic            fpr_q, fpr_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [7:0]      addr;

  // State, position counter, timeout counter and captured record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      grp_q   <= G_XPR;
      idx_q   <= '0;
      fpr_q   <= 1'b0;
      tmo_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      idx_q   <= idx_d;
      fpr_q   <= fpr_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
    end
  end

  // Next state; the position only advances on an accepted core write.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    idx_d   = idx_q;
    fpr_d   = fpr_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_REQ;
        grp_d   = G_XPR;
        idx_d   = 5'd1;
        fpr_d   = fpr_en_i;
      end
      S_REQ: if (bus.src_req_ready) begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        if (bus.src_resp_valid) begin
          data_d  = bus.src_resp_data;
          state_d = S_WRITE;
        end else if (tmo_q == TMO_MAX) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WRITE: if (bus.wr_ready) begin
        state_d = S_REQ;
        case (grp_q)
          G_XPR: if (idx_q == 5'd31) begin
            grp_d = fpr_q ? G_FPR : G_CSR;
            idx_d = '0;
          end else idx_d = idx_q + 5'd1;
          G_FPR: if (idx_q == 5'd31) begin
            grp_d = G_CSR;
            idx_d = '0;
          end else idx_d = idx_q + 5'd1;
          G_CSR: if (idx_q == CSR_LAST) begin
            grp_d = G_PC;
            idx_d = '0;
          end else idx_d = idx_q + 5'd1;
          default: state_d = S_DONE;
        endcase
      end
      default: ;
    endcase
  end

  // Fixed source address map derived from the current group/index.
  always_comb begin
    case (grp_q)
      G_XPR:   addr = 8'(idx_q) - 8'd1;
      G_FPR:   addr = 8'd31 + 8'(idx_q);
      G_CSR:   addr = 8'd63 + 8'(idx_q);
      default: addr = PC_ADDR;
    endcase
  end

  assign bus.src_req_valid = (state_q == S_REQ);
  assign bus.src_req_addr  = addr;
  assign bus.wr_valid      = (state_q == S_WRITE);
  assign bus.wr_sel        = grp_q;
  assign bus.wr_idx        = idx_q;
  assign bus.wr_data       = data_q;

  assign core_hold_o = (state_q != S_DONE);
  assign busy_o      = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_WRITE);
  assign done_o      = (state_q == S_DONE);
  assign error_o     = (state_q == S_ERROR);
endmodule

// File: tb/tb_arch_restore_sequencer.sv
// Directed-plus-random bench for the restore sequencer. A source model and a
// core model run alongside the main sequence; expected traffic is derived from
// the address map with plain loops.
module tb_arch_restore_sequencer;
  localparam int XLEN    = 64;
  localparam int NUM_CSR = 24;
  localparam int TIMEOUT = 1023;

  typedef struct packed {
    logic [1:0]      sel;
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
  } wr_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, fpr_en = 1'b0;
  logic core_hold, busy, done, error;

  arch_restore_sequencer_if #(.XLEN(XLEN)) bus ();

  arch_restore_sequencer #(.XLEN(XLEN), .NUM_CSR(NUM_CSR), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .fpr_en_i(fpr_en), .bus(bus),
    .core_hold_o(core_hold), .busy_o(busy), .done_o(done), .error_o(error)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc_g = 0, hs_cyc = 0;
  int unst_src = 0, unst_wr = 0;
  int rdy_pct = 100, wr_pct = 100, lat_min = 1, lat_max = 1;
  int never_addr = -1, slow_addr = -1, slow_lat = 0;
  bit spurious = 1'b0;
  logic [XLEN-1:0] mem [256];
  logic [7:0] aq[$], exp_a[$];
  wr_t        wq[$], exp_w[$];

  initial forever begin
    @(posedge clk);
    cyc_g++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Source: a "1-cycle" answer arrives one full cycle after the request is accepted.
  initial begin : src_model
    bit pend, hold, hung;
    int cnt;
    logic [7:0] a, ha;
    pend = 0; hold = 0; hung = 0; cnt = 0; a = '0; ha = '0;
    bus.src_req_ready = 1'b0; bus.src_resp_valid = 1'b0; bus.src_resp_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; hold = 0; hung = 0;
        bus.src_req_ready = 1'b0; bus.src_resp_valid = 1'b0;
        continue;
      end
      if (hold && (bus.src_req_valid !== 1'b1 || bus.src_req_addr !== ha)) unst_src++;
      bus.src_resp_valid = 1'b0;
      bus.src_resp_data  = {$urandom, $urandom};
      if (pend) begin
        if (cnt == 0) begin
          bus.src_resp_valid = 1'b1;
          bus.src_resp_data  = mem[a];
          pend = 0;
        end else cnt--;
      end else if (spurious && !hung && $urandom_range(0, 2) == 0) begin
        bus.src_resp_valid = 1'b1;
      end
      bus.src_req_ready = ($urandom_range(1, 100) <= rdy_pct);
      hold = bus.src_req_valid && !bus.src_req_ready;
      ha   = bus.src_req_addr;
      if (bus.src_req_valid && bus.src_req_ready) begin
        a = bus.src_req_addr;
        aq.push_back(a);
        hs_cyc = cyc_g + 1;
        if (int'(a) == never_addr) hung = 1;
        else begin
          pend = 1;
          cnt  = (int'(a) == slow_addr) ? slow_lat : $urandom_range(lat_min, lat_max);
        end
      end
    end
  end

  // Core write port: random acceptance, logs accepted writes.
  initial begin : core_model
    bit hold;
    wr_t hv, cur;
    hold = 0; hv = '0;
    bus.wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0; bus.wr_ready = 1'b0;
        continue;
      end
      cur = '{sel: bus.wr_sel, idx: bus.wr_idx, data: bus.wr_data};
      if (hold && (bus.wr_valid !== 1'b1 || cur !== hv)) unst_wr++;
      bus.wr_ready = ($urandom_range(1, 100) <= wr_pct);
      hv   = cur;
      hold = bus.wr_valid && !bus.wr_ready;
      if (bus.wr_valid && bus.wr_ready) wq.push_back(cur);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(input int g, input int i, input int a);
    exp_a.push_back(8'(a));
    exp_w.push_back('{sel: 2'(g), idx: 5'(i), data: mem[a]});
  endfunction

  // Expected restore order straight from the address map.
  function automatic void build_exp(input bit fe);
    exp_a.delete(); exp_w.delete();
    for (int r = 1; r < 32; r++) add(0, r, r - 1);
    if (fe) for (int r = 0; r < 32; r++) add(1, r, 31 + r);
    for (int s = 0; s < NUM_CSR; s++) add(2, s, 63 + s);
    add(3, 0, 63 + NUM_CSR);
  endfunction

  task automatic cmp_seq(input string tag);
    int bad = 0;
    chk({tag, "_nwr"}, wq.size(), exp_w.size());
    chk({tag, "_nreq"}, aq.size(), exp_a.size());
    for (int k = 0; k < exp_w.size(); k++) begin
      if (k >= wq.size() || wq[k] !== exp_w[k]) bad++;
      if (k >= aq.size() || aq[k] !== exp_a[k]) bad++;
    end
    chk({tag, "_order"}, bad, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hold"}, int'(core_hold), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(error), 0);
    chk({tag, "_reqv"}, int'(bus.src_req_valid), 0);
    chk({tag, "_wrv"}, int'(bus.wr_valid), 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #3 rst_n = 1'b0; start = 1'b0;
    #1 chk_reset(tag);
    repeat (3) @(negedge clk);
    aq.delete(); wq.delete(); unst_src = 0; unst_wr = 0;
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  // Pulse start and wait for a terminal state; optional re-pokes of start.
  task automatic run(input string tag, input bit fe, input bit poke, output int cyc);
    int nb = 0;
    @(negedge clk); fpr_en = fe; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; fpr_en = ~fe;
    cyc = 0;
    while (!done && !error && cyc < 20000) begin
      @(posedge clk); #1 cyc++;
      start = poke && (cyc % 7 == 3);
      if (!done && !error && !busy) nb++;
    end
    start = 1'b0;
    chk({tag, "_busy_run"}, nb, 0);
    chk({tag, "_finished"}, int'(done || error), 1);
  endtask

  initial begin : main
    int cyc, n;
    for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom};

    // Power-on reset and idle without start
    repeat (2) @(negedge clk);
    chk_reset("por");
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_hold", int'(core_hold), 1);
    chk("idle_busy", int'(busy), 0);

    // Full restore, ideal handshakes
    build_exp(1'b1);
    run("t1", 1'b1, 1'b0, cyc);
    chk("t1_cycles", cyc, 352);
    chk("t1_done", int'(done), 1);
    chk("t1_hold", int'(core_hold), 0);
    chk("t1_err", int'(error), 0);
    cmp_seq("t1");

    // FPR group skipped
    do_reset("t2rst");
    build_exp(1'b0);
    run("t2", 1'b0, 1'b0, cyc);
    chk("t2_cycles", cyc, 224);
    n = 0;
    foreach (aq[k]) if (aq[k] >= 8'd31 && aq[k] <= 8'd62) n++;
    chk("t2_no_fpr_addr", n, 0);
    chk("t2_csr0_after_x31", (aq.size() > 31) ? int'(aq[31]) : -1, 63);
    cmp_seq("t2");

    // Random backpressure and response latency
    do_reset("t3rst");
    rdy_pct = 50; wr_pct = 50; lat_min = 0; lat_max = 3;
    build_exp(1'b1);
    run("t3", 1'b1, 1'b0, cyc);
    chk("t3_done", int'(done), 1);
    chk("t3_req_stable", unst_src, 0);
    chk("t3_wr_stable", unst_wr, 0);
    cmp_seq("t3");
    rdy_pct = 100; wr_pct = 100; lat_min = 1; lat_max = 1;

    // Source never answers addr 5
    do_reset("t4rst");
    never_addr = 5;
    run("t4", 1'b1, 1'b0, cyc);
    chk("t4_err", int'(error), 1);
    chk("t4_tmo_cycles", cyc_g - hs_cyc, TIMEOUT + 1);
    chk("t4_hold", int'(core_hold), 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_nwr", wq.size(), 5);
    chk("t4_last_idx", (wq.size() > 0) ? int'(wq[wq.size()-1].idx) : -1, 5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_sticky_err", int'(error), 1);
    chk("t4_no_req", int'(bus.src_req_valid), 0);
    never_addr = -1;

    // Reset in the middle of the FPR group
    do_reset("t5rst");
    @(negedge clk); fpr_en = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (wq.size() < 40 && n < 1000) begin @(negedge clk); n++; end
    chk("t5_reached_fpr", int'(wq.size() >= 40), 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_reset("t5mid");
    repeat (3) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    aq.delete(); wq.delete();
    repeat (5) @(negedge clk);
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_idle_nreq", aq.size(), 0);
    build_exp(1'b1);
    run("t5", 1'b1, 1'b0, cyc);
    chk("t5_cycles", cyc, 352);
    cmp_seq("t5");

    // Start re-pulsed while busy, spurious responses outside WAIT
    do_reset("t6rst");
    spurious = 1'b1;
    build_exp(1'b1);
    run("t6", 1'b1, 1'b1, cyc);
    chk("t6_cycles", cyc, 352);
    cmp_seq("t6");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_sticky_done", int'(done), 1);
    chk("t6_post_busy", int'(busy), 0);
    spurious = 1'b0;

    // Response on the last allowed wait cycle still wins
    do_reset("t7rst");
    slow_addr = 0; slow_lat = TIMEOUT;
    build_exp(1'b0);
    run("t7", 1'b0, 1'b0, cyc);
    chk("t7_err", int'(error), 0);
    chk("t7_cycles", cyc, 224 + TIMEOUT - 1);
    cmp_seq("t7");
    slow_addr = -1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
